// File: rtl/common.sv
// common: instruction-bus types and the architectural reset PC shared across the core.
package common;
    localparam logic [63:0] PCINIT = 64'h8000_0000;
    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
    } ibus_req_t;
    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [63:0] data;
    } ibus_resp_t;
endpackage

// File: rtl/pipes.sv
// pipes: inter-stage payload types and the fetch FSM state encoding.
package pipes;
    typedef struct packed {
        logic [31:0] raw_instr;
        logic [63:0] pc;
    } instr_t;
    typedef struct packed {
        logic   valid;
        instr_t instr;
    } fetch_data_t;
    typedef enum logic [1:0] {IDLE, REQ, DRAIN} fetch_state_t;
endpackage

// File: rtl/fetch.sv
// fetch: owns the PC, keeps one bus request in flight and buffers one instruction for decode.
module fetch
    import common::*, pipes::*;
#(
    parameter logic [63:0] PC_RESET = PCINIT
) (
    input  logic        clk,
    input  logic        reset,
    output ibus_req_t   ireq,
    input  ibus_resp_t  iresp,
    output fetch_data_t dataF,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc
);
    fetch_state_t state, state_n;
    logic [63:0] pc, pc_n, pc_pending, pending_n, buf_pc, buf_pc_n;
    logic [31:0] buf_instr, buf_instr_n;
    logic        buf_valid, buf_valid_n, accept;
    logic        unused_resp;

    assign unused_resp = ^{iresp.addr_ok, iresp.data[63:32]};
    assign accept = buf_valid && !stall;
    assign ireq = {state == REQ || state == DRAIN, pc};
    assign dataF = {buf_valid, buf_instr, buf_pc};

    always_comb begin
        state_n = state;
        pc_n = pc;
        pending_n = pc_pending;
        buf_valid_n = buf_valid && !accept;
        buf_instr_n = buf_instr;
        buf_pc_n = buf_pc;
        if (redirect_valid) begin
            buf_valid_n = 1'b0;
            if (state == DRAIN || (state == REQ && !iresp.data_ok))
                pending_n = redirect_pc;
            // An outstanding request must finish at its old address before the target is fetched.
            if (iresp.data_ok || state == IDLE) begin
                pc_n = redirect_pc;
                state_n = IDLE;
            end else begin
                state_n = DRAIN;
            end
        end else if (state == IDLE) begin
            state_n = (!buf_valid || accept) ? REQ : IDLE;
        end else if (iresp.data_ok) begin
            state_n = IDLE;
            if (state == REQ) begin
                buf_valid_n = 1'b1;
                buf_instr_n = iresp.data[31:0];
                buf_pc_n = pc;
                pc_n = pc + 64'd4;
            end else begin
                pc_n = pc_pending;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            pc <= PC_RESET;
            pc_pending <= '0;
            buf_valid <= 1'b0;
            buf_instr <= '0;
            buf_pc <= '0;
        end else begin
            state <= state_n;
            pc <= pc_n;
            pc_pending <= pending_n;
            buf_valid <= buf_valid_n;
            buf_instr <= buf_instr_n;
            buf_pc <= buf_pc_n;
        end
    end
endmodule

// File: tb/tb_fetch.sv
// tb_fetch: directed stimulus with a scoreboard of instructions decode must receive, in order.
module tb_fetch;
    import common::*, pipes::*;

    logic        clk, clk_en, reset, stall, redirect_valid;
    logic [63:0] redirect_pc;
    logic [31:0] rdata;
    int          lat, wait_cnt;
    ibus_req_t   ireq;
    ibus_resp_t  iresp;
    fetch_data_t dataF;
    instr_t      exp_q[$];
    int          n_checks = 0, n_fail = 0;
    logic        pv;
    logic [63:0] pa;

    fetch dut (
        .clk(clk), .reset(reset), .ireq(ireq), .iresp(iresp), .dataF(dataF),
        .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    // Bus answers a request after lat extra cycles (lat=0: same cycle).
    assign iresp = {ireq.valid, ireq.valid && (wait_cnt == lat), 32'hffff_0000, rdata};

    always @(posedge clk or negedge reset)
        if (!reset) wait_cnt <= 0;
        else wait_cnt <= (!ireq.valid || iresp.data_ok) ? 0 : wait_cnt + 1;

    initial clk = 1'b0;
    always #5 if (clk_en) clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push(input logic [63:0] pc, input logic [31:0] instr);
        instr_t e;
        e.pc = pc;
        e.raw_instr = instr;
        exp_q.push_back(e);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk or negedge reset) begin
        if (!reset) begin
            pv = 1'b0;
        end else begin
            if (pv) begin
                chk("req_hold_valid", 64'(ireq.valid), 64'd1);
                chk("req_hold_addr", ireq.addr, pa);
            end
            pv = ireq.valid && !iresp.data_ok;
            pa = ireq.addr;
            if (dataF.valid && !stall) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_dataF: got pc %h instr %h, expected nothing", dataF.instr.pc, dataF.instr.raw_instr);
                end else begin
                    instr_t e;
                    e = exp_q.pop_front();
                    chk("dataF_pc", dataF.instr.pc, e.pc);
                    chk("dataF_instr", 64'(dataF.instr.raw_instr), 64'(e.raw_instr));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    logic [63:0] t1_pc [3] = '{64'h8000_0000, 64'h8000_0004, 64'h8000_0008};
    logic [31:0] t1_dat[3] = '{32'h0000_0013, 32'h0020_0113, 32'h0010_0093};

    initial begin
        reset = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        lat = 0; rdata = '0; clk_en = 1'b1;
        tick; tick;
        chk("rst_req_valid", 64'(ireq.valid), 64'd0);
        chk("rst_req_addr", ireq.addr, 64'h8000_0000);
        chk("rst_dataF_valid", 64'(dataF.valid), 64'd0);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) push(t1_pc[i], t1_dat[i]);
        for (int i = 0; i < 3; i++) begin
            rdata = t1_dat[i];
            tick;
            chk("t1_req_valid", 64'(ireq.valid), 64'd1);
            chk("t1_req_addr", ireq.addr, t1_pc[i]);
            tick;
            chk("t1_dataF_valid", 64'(dataF.valid), 64'd1);
            chk("t1_req_idle", 64'(ireq.valid), 64'd0);
        end
        stall = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk("stall_valid", 64'(dataF.valid), 64'd1);
            chk("stall_pc", dataF.instr.pc, 64'h8000_0008);
            chk("stall_instr", 64'(dataF.instr.raw_instr), 64'h0010_0093);
            chk("stall_no_req", 64'(ireq.valid), 64'd0);
            tick;
        end
        stall = 1'b0;
        rdata = 32'h0030_0193;
        chk("unstall_no_req_yet", 64'(ireq.valid), 64'd0);
        tick;
        chk("unstall_req_valid", 64'(ireq.valid), 64'd1);
        chk("unstall_req_addr", ireq.addr, 64'h8000_000c);
        stall = 1'b1;
        tick;
        chk("t3_buf_full", 64'(dataF.valid), 64'd1);
        redirect_valid = 1'b1; redirect_pc = 64'h8000_0100;
        tick;
        redirect_valid = 1'b0; stall = 1'b0;
        chk("t3_flush", 64'(dataF.valid), 64'd0);
        chk("t3_no_req", 64'(ireq.valid), 64'd0);
        rdata = 32'h0040_0213;
        push(64'h8000_0100, 32'h0040_0213);
        tick;
        chk("t3_req_valid", 64'(ireq.valid), 64'd1);
        chk("t3_req_addr", ireq.addr, 64'h8000_0100);
        tick;
        chk("t3_dataF_valid", 64'(dataF.valid), 64'd1);
        rdata = 32'hdead_beef;
        tick;
        chk("t5_req_addr", ireq.addr, 64'h8000_0104);
        redirect_valid = 1'b1; redirect_pc = 64'h8000_0010;
        tick;
        redirect_valid = 1'b0;
        chk("t5_dropped", 64'(dataF.valid), 64'd0);
        chk("t5_no_req", 64'(ireq.valid), 64'd0);
        lat = 3;
        tick;
        chk("t5_req_valid", 64'(ireq.valid), 64'd1);
        chk("t5_req_target", ireq.addr, 64'h8000_0010);
        redirect_valid = 1'b1; redirect_pc = 64'h8000_0200;
        tick;
        redirect_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("drain_valid", 64'(ireq.valid), 64'd1);
            chk("drain_addr", ireq.addr, 64'h8000_0010);
            chk("drain_dataF", 64'(dataF.valid), 64'd0);
            tick;
        end
        chk("drain_done_idle", 64'(ireq.valid), 64'd0);
        chk("drain_discard", 64'(dataF.valid), 64'd0);
        lat = 0; rdata = 32'h0050_0293;
        push(64'h8000_0200, 32'h0050_0293);
        tick;
        chk("t4_req_valid", 64'(ireq.valid), 64'd1);
        chk("t4_req_addr", ireq.addr, 64'h8000_0200);
        tick;
        chk("t4_dataF_valid", 64'(dataF.valid), 64'd1);
        lat = 5;
        tick;
        chk("t6_req_valid", 64'(ireq.valid), 64'd1);
        chk("t6_req_addr", ireq.addr, 64'h8000_0204);
        clk_en = 1'b0;
        #2 reset = 1'b0;
        #1;
        chk("t6_async_req", 64'(ireq.valid), 64'd0);
        chk("t6_async_dataF", 64'(dataF.valid), 64'd0);
        chk("t6_async_addr", ireq.addr, 64'h8000_0000);
        #10 reset = 1'b1;
        lat = 0; rdata = 32'h0060_0313;
        push(64'h8000_0000, 32'h0060_0313);
        #2 clk_en = 1'b1;
        tick;
        chk("t6_restart_valid", 64'(ireq.valid), 64'd1);
        chk("t6_restart_addr", ireq.addr, 64'h8000_0000);
        tick;
        chk("t6_restart_dataF", 64'(dataF.valid), 64'd1);
        tick; tick;
        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
